// File: rtl/lcd_stream_ctrl.sv
// rtl/lcd_stream_ctrl.sv - HD44780 character LCD controller fed by a valid/ready byte stream
module lcd_stream_ctrl #(
    parameter int DATA_4BIT = 0,
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int EN_CYCLES = 25,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int PWR_WAIT  = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       init_done
);
    typedef enum logic [2:0] {
        S_PWR, S_IDLE, S_ACCEPT, S_DECODE, S_SETUP, S_PULSE, S_GAP, S_WAIT
    } state_t;

    localparam logic [2:0] LAST_INIT = (DATA_4BIT != 0) ? 3'd7 : 3'd6;

    // Returns {single_nibble, long_wait, byte} for each step of the power-on sequence.
    function automatic logic [9:0] init_op(input logic [2:0] idx);
        if (DATA_4BIT != 0) begin
            case (idx)
                3'd0:    init_op = {2'b11, 8'h30};
                3'd1:    init_op = {2'b10, 8'h30};
                3'd2:    init_op = {2'b10, 8'h30};
                3'd3:    init_op = {2'b10, 8'h20};
                3'd4:    init_op = {2'b00, 8'h28};
                3'd5:    init_op = {2'b00, 8'h0C};
                3'd6:    init_op = {2'b00, 8'h06};
                default: init_op = {2'b01, 8'h01};
            endcase
        end else begin
            case (idx)
                3'd0:    init_op = {2'b01, 8'h30};
                3'd1:    init_op = {2'b00, 8'h30};
                3'd2:    init_op = {2'b00, 8'h30};
                3'd3:    init_op = {2'b00, 8'h38};
                3'd4:    init_op = {2'b00, 8'h0C};
                3'd5:    init_op = {2'b00, 8'h06};
                default: init_op = {2'b01, 8'h01};
            endcase
        end
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, lim;
    logic [7:0]  op_byte_q, op_byte_d, byte_q, byte_d;
    logic        op_rs_q, op_rs_d, op_long_q, op_long_d, op_single_q, op_single_d;
    logic        nib_lo_q, nib_lo_d, pend_q, pend_d, done_q, done_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic        row_q, row_d, next_row;
    logic [5:0]  col_q, col_d;
    logic        cnt_last;

    assign next_row = (ROWS == 2) ? ~row_q : 1'b0;

    always_comb begin
        case (state_q)
            S_PWR:         lim = 32'(PWR_WAIT);
            S_PULSE, S_GAP: lim = 32'(EN_CYCLES);
            S_WAIT:        lim = op_long_q ? 32'(CLR_WAIT) : 32'(CMD_WAIT);
            default:       lim = 32'd1;
        endcase
    end
    assign cnt_last = (cnt_q == lim - 32'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        op_byte_d   = op_byte_q;
        op_rs_d     = op_rs_q;
        op_long_d   = op_long_q;
        op_single_d = op_single_q;
        nib_lo_d    = nib_lo_q;
        pend_d      = pend_q;
        done_d      = done_q;
        init_idx_d  = init_idx_q;
        byte_d      = byte_q;
        row_d       = row_q;
        col_d       = col_q;
        case (state_q)
            S_PWR: if (cnt_last) begin
                {op_single_d, op_long_d, op_byte_d} = init_op(3'd0);
                op_rs_d    = 1'b0;
                nib_lo_d   = 1'b0;
                init_idx_d = 3'd0;
                state_d    = S_SETUP;
            end
            S_IDLE: if (in_valid) begin
                byte_d  = in_data;
                state_d = S_ACCEPT;
            end
            S_ACCEPT: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_IDLE;
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    // Position the cursor explicitly before every character.
                    {op_single_d, op_long_d, op_rs_d, nib_lo_d} = 4'b0000;
                    op_byte_d = {1'b1, row_q, col_q};
                    pend_d    = 1'b1;
                    state_d   = S_SETUP;
                end else if (byte_q == 8'h0A) begin
                    col_d = 6'd0;
                    row_d = next_row;
                end else if (byte_q == 8'h0C) begin
                    {op_single_d, op_rs_d, nib_lo_d} = 3'b000;
                    op_long_d = 1'b1;
                    op_byte_d = 8'h01;
                    row_d     = 1'b0;
                    col_d     = 6'd0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: state_d = S_PULSE;
            S_PULSE: if (cnt_last) begin
                if (DATA_4BIT != 0 && !op_single_q && !nib_lo_q) state_d = S_GAP;
                else state_d = S_WAIT;
            end
            S_GAP: if (cnt_last) begin
                nib_lo_d = 1'b1;
                state_d  = S_SETUP;
            end
            S_WAIT: if (cnt_last) begin
                if (!done_q) begin
                    if (init_idx_q == LAST_INIT) begin
                        done_d  = 1'b1;
                        row_d   = 1'b0;
                        col_d   = 6'd0;
                        state_d = S_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        {op_single_d, op_long_d, op_byte_d} = init_op(init_idx_q + 3'd1);
                        nib_lo_d = 1'b0;
                        state_d  = S_SETUP;
                    end
                end else if (pend_q) begin
                    {op_single_d, op_long_d, nib_lo_d, pend_d} = 4'b0000;
                    op_rs_d   = 1'b1;
                    op_byte_d = byte_q;
                    state_d   = S_SETUP;
                end else begin
                    if (op_rs_q) begin
                        if (col_q == 6'(COLS - 1)) begin
                            col_d = 6'd0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_PWR;
        endcase
        if (state_d != state_q) cnt_d = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWR;
            cnt_q       <= 32'd0;
            op_byte_q   <= 8'h00;
            op_rs_q     <= 1'b0;
            op_long_q   <= 1'b0;
            op_single_q <= 1'b0;
            nib_lo_q    <= 1'b0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            init_idx_q  <= 3'd0;
            byte_q      <= 8'h00;
            row_q       <= 1'b0;
            col_q       <= 6'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_byte_q   <= op_byte_d;
            op_rs_q     <= op_rs_d;
            op_long_q   <= op_long_d;
            op_single_q <= op_single_d;
            nib_lo_q    <= nib_lo_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            init_idx_q  <= init_idx_d;
            byte_q      <= byte_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign lcd_en    = (state_q == S_PULSE);
    assign lcd_rs    = op_rs_q;
    assign lcd_rw    = 1'b0;
    assign init_done = done_q;
    assign lcd_data  = (DATA_4BIT != 0) ?
                       {(nib_lo_q ? op_byte_q[3:0] : op_byte_q[7:4]), 4'h0} : op_byte_q;
endmodule
